fp_sig_divider_iter: RTL and testbench

FP_SIG_DIVIDER_ITER -- requirements
Module: fp_sig_divider_iter

---
 rtl/fp_sig_divider_iter.sv | 131 +++++++++++++
 tb/tb_fp_sig_divider_iter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fp_sig_divider_iter.sv
// Iterative restoring divider for floating-point significands, one quotient bit per clock.
// Double mode produces MW+2 quotient bits; single mode produces SW+2 bits, left-aligned in q.
module fp_sig_divider_iter #(
  parameter int unsigned MW = 53,
  parameter int unsigned SW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          db,
  input  logic [MW-1:0] fa,
  input  logic [MW-1:0] fb,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW+1:0] q,
  output logic          sticky,
  output logic          dbz
);

  localparam int unsigned QW = MW + 2;
  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [MW:0]     r_rem;
  logic [MW-1:0]   r_div;
  logic            r_db;
  logic [QW-1:0]   r_q;
  logic            r_sticky;
  logic            r_dbz;
  logic            r_out_valid;
  logic            r_in_ready;

  logic [MW-1:0]   w_fa_m;
  logic [MW-1:0]   w_fb_m;
  logic            w_ge;
  logic [MW:0]     w_sub;
  logic [MW:0]     w_rem_next;
  logic [QW-1:0]   w_q_shift;
  logic [QW-1:0]   w_q_final;
  logic            w_last;

  // Single mode keeps only the top SW bits of each operand.
  assign w_fa_m = db ? fa : {fa[MW-1:MW-SW], {(MW-SW){1'b0}}};
  assign w_fb_m = db ? fb : {fb[MW-1:MW-SW], {(MW-SW){1'b0}}};

  assign w_ge       = r_rem >= {1'b0, r_div};
  assign w_sub      = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
  assign w_rem_next = {w_sub[MW-1:0], 1'b0};
  assign w_q_shift  = {r_q[QW-2:0], w_ge};
  assign w_q_final  = r_db ? w_q_shift : (w_q_shift << (MW - SW));
  assign w_last     = r_cnt == CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_db        <= 1'b0;
      r_q         <= '0;
      r_sticky    <= 1'b0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_db       <= db;
            r_div      <= w_fb_m;
            r_rem      <= {1'b0, w_fa_m};
            r_cnt      <= db ? CW'(QW) : CW'(SW + 2);
            r_q        <= '0;
            r_sticky   <= 1'b0;
            r_dbz      <= (w_fb_m == '0);
            r_state    <= StIter;
            r_in_ready <= 1'b0;
          end
        end
        StIter: begin
          if (r_dbz) begin
            r_q         <= '1;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
            r_state     <= StDone;
            r_out_valid <= 1'b1;
          end else begin
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
              r_q         <= w_q_final;
              r_sticky    <= |w_rem_next;
              r_state     <= StDone;
              r_out_valid <= 1'b1;
            end else begin
              r_q <= w_q_shift;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign sticky    = r_sticky;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_fp_sig_divider_iter.sv
// Randomized bench for fp_sig_divider_iter against an arithmetic quotient model,
// plus directed cases for divide-by-zero, flush, reset and output hold.
module tb_fp_sig_divider_iter;

  localparam int MW = 53;
  localparam int SW = 24;
  localparam int QW = MW + 2;
  localparam logic [MW-1:0] Hid = {1'b1, {(MW-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          db;
  logic [MW-1:0] fa;
  logic [MW-1:0] fb;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] q;
  logic          sticky;
  logic          dbz;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_sig_divider_iter #(.MW(MW), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .db        (db),
    .fa        (fa),
    .fb        (fb),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .sticky    (sticky),
    .dbz       (dbz)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Quotient = floor(a * 2^(bits-1) / b), bits = QW (double) or SW+2 (single).
  task automatic model(input logic dbm, input logic [MW-1:0] a, input logic [MW-1:0] b,
                       output logic [QW-1:0] eq, output logic es, output logic ez,
                       output int lat);
    logic [127:0] num;
    logic [127:0] den;
    logic [127:0] quo;
    logic [SW-1:0] as;
    logic [SW-1:0] bs;
    if (dbm) begin
      num = 128'(a) << (QW - 1);
      den = 128'(b);
      lat = QW;
    end else begin
      as  = a[MW-1:MW-SW];
      bs  = b[MW-1:MW-SW];
      num = 128'(as) << (SW + 1);
      den = 128'(bs);
      lat = SW + 2;
    end
    if (den == 0) begin
      eq  = '1;
      es  = 1'b0;
      ez  = 1'b1;
      lat = 1;
    end else begin
      quo = num / den;
      es  = (num % den) != 0;
      ez  = 1'b0;
      eq  = dbm ? quo[QW-1:0] : (quo[QW-1:0] << (MW - SW));
    end
  endtask

  function automatic logic [MW-1:0] rnd_sig();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return {1'b1, t[MW-2:0]};
  endfunction

  task automatic run_op(input logic dbm, input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input int hold, input bit noise);
    logic [QW-1:0] eq;
    logic          es;
    logic          ez;
    int            lat;
    int            cyc;
    model(dbm, a, b, eq, es, ez, lat);
    check("in_ready_idle", 128'(in_ready), 128'(1));
    db = dbm; fa = a; fb = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (noise) begin
        in_valid = 1'($urandom);
        db = 1'($urandom);
        fa = rnd_sig();
        fb = MW'(0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 128'(cyc), 128'(lat));
    check("q", 128'(q), 128'(eq));
    check("sticky", 128'(sticky), 128'(es));
    check("dbz", 128'(dbz), 128'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_in_ready", 128'(in_ready), 128'(0));
      check("hold_q", 128'(q), 128'(eq));
      check("hold_sticky", 128'(sticky), 128'(es));
      check("hold_dbz", 128'(dbz), 128'(ez));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", 128'(out_valid), 128'(0));
    check("drain_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; db = 1'b1; fa = '0; fb = '0; flush = 1'b0; out_ready = 1'b0;
    #22 rst = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_q", 128'(q), 128'(0));
    check("rst_sticky", 128'(sticky), 128'(0));
    check("rst_dbz", 128'(dbz), 128'(0));
    @(posedge clk); #1;

    run_op(1'b1, Hid, Hid, 0, 1'b0);
    run_op(1'b1, Hid, Hid | (Hid >> 1), 2, 1'b0);
    run_op(1'b0, Hid, Hid | MW'(29'h1abc_def5), 0, 1'b0);
    run_op(1'b1, Hid, MW'(0), 5, 1'b0);
    run_op(1'b0, rnd_sig(), MW'(29'h0f0f_0f0f), 1, 1'b0);

    for (int k = 0; k < 20; k++)
      run_op(1'($urandom), rnd_sig(), rnd_sig(), int'($urandom_range(0, 2)), 1'b1);

    // Flush in IDLE must win over a simultaneous request.
    in_valid = 1'b1; flush = 1'b1; db = 1'b1; fa = rnd_sig(); fb = rnd_sig();
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 128'(in_ready), 128'(1));

    // Flush ten cycles into an operation, then start a fresh one.
    db = 1'b1; fa = rnd_sig(); fb = rnd_sig(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    run_op(1'b1, rnd_sig(), rnd_sig(), 0, 1'b0);

    // Reset pulse mid-iteration.
    db = 1'b0; fa = rnd_sig(); fb = rnd_sig(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("rst_async_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(out_valid), 128'(0));
    check("rst_mid_in_ready", 128'(in_ready), 128'(1));
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_no_stale", 128'(seen), 128'(0));
    run_op(1'b0, rnd_sig(), rnd_sig(), 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
